// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Purpose : RISC-V instruction fetch with PC, single-outstanding imem requests,
//           one-word skid buffer and IF/ID pipeline register.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int unsigned      size     = 32,
  parameter logic [size-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [size-1:0] imem_addr,
  input  logic [size-1:0] imem_rdata,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            redirect,
  input  logic [size-1:0] redirect_pc,
  output logic            id_valid,
  output logic [size-1:0] id_instruction,
  output logic [size-1:0] id_pc,
  output logic [size-1:0] id_pc_plus4
);

  localparam logic [size-1:0] NOP      = size'(32'h0000_0013);
  localparam logic [size-1:0] PC_STEP  = size'(4);
  localparam logic [size-1:0] PC_RESET = {RESET_PC[size-1:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [size-1:0] pc, pc_n;
  logic [size-1:0] skid, skid_n;
  logic            idv_n;
  logic [size-1:0] idi_n, idpc_n;

  // The PC register doubles as the registered fetch address.
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign id_pc_plus4 = id_pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= PC_RESET;
      skid           <= NOP;
      id_valid       <= 1'b0;
      id_instruction <= NOP;
      id_pc          <= '0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      skid           <= skid_n;
      id_valid       <= idv_n;
      id_instruction <= idi_n;
      id_pc          <= idpc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    skid_n  = skid;
    idv_n   = id_valid;
    idi_n   = id_instruction;
    idpc_n  = id_pc;

    if (redirect) begin
      // Flush beats stall; an unanswered request must be drained before refetch.
      pc_n  = {redirect_pc[size-1:2], 2'b00};
      idv_n = 1'b0;
      idi_n = NOP;
      if (((state == REQ) || (state == DRAIN)) && !imem_valid)
        state_n = DRAIN;
      else
        state_n = REQ;
    end else begin
      case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (imem_valid) begin
            if (!stall) begin
              idv_n  = 1'b1;
              idi_n  = imem_rdata;
              idpc_n = pc;
              pc_n   = pc + PC_STEP;
            end else begin
              skid_n  = imem_rdata;
              state_n = HOLD;
            end
          end else if (!stall) begin
            idv_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            idv_n   = 1'b1;
            idi_n   = skid;
            idpc_n  = pc;
            pc_n    = pc + PC_STEP;
            state_n = REQ;
          end
        end
        DRAIN: begin
          if (imem_valid) state_n = REQ;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Purpose : Directed vector bench for fetch_stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int checks;
  int failures;

  fetch_stage #(.size(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        idv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } vec_t;

  function automatic vec_t v(input logic r, input logic s, input logic rd,
                             input logic [31:0] rpc, input logic vl,
                             input logic [31:0] dat, input logic rq,
                             input logic [31:0] ad, input logic iv,
                             input logic [31:0] ins, input logic [31:0] p,
                             input logic [31:0] p4);
    vec_t t;
    t.rst = r; t.stall = s; t.redirect = rd; t.rpc = rpc; t.valid = vl;
    t.rdata = dat; t.req = rq; t.addr = ad; t.idv = iv; t.instr = ins;
    t.pc = p; t.pc4 = p4;
    return t;
  endfunction

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  // Drive on the falling edge, compare 1ns after the rising edge.
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    rst         = t.rst;
    stall       = t.stall;
    redirect    = t.redirect;
    redirect_pc = t.rpc;
    imem_valid  = t.valid;
    imem_rdata  = t.rdata;
    @(posedge clk);
    #1;
    chk("imem_req",       idx, {31'd0, imem_req}, {31'd0, t.req});
    chk("imem_addr",      idx, imem_addr,         t.addr);
    chk("id_valid",       idx, {31'd0, id_valid}, {31'd0, t.idv});
    chk("id_instruction", idx, id_instruction,    t.instr);
    chk("id_pc",          idx, id_pc,             t.pc);
    chk("id_pc_plus4",    idx, id_pc_plus4,       t.pc4);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  vec_t tbl[20];

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0;

    //          rst st rd rpc           vl dat              req addr          iv instr             pc            pc4
    tbl[0]  = v(1, 0, 0, 32'h0,        0, 32'h0,           0, 32'h0,        0, NOP,              32'h0,        32'h4);
    tbl[1]  = v(1, 0, 0, 32'h0,        1, 32'h1234_5678,   0, 32'h0,        0, NOP,              32'h0,        32'h4);
    tbl[2]  = v(0, 0, 0, 32'h0,        0, 32'h0,           1, 32'h0,        0, NOP,              32'h0,        32'h4);
    tbl[3]  = v(0, 0, 0, 32'h0,        1, w(32'h0),        1, 32'h4,        1, w(32'h0),         32'h0,        32'h4);
    tbl[4]  = v(0, 0, 0, 32'h0,        1, w(32'h4),        1, 32'h8,        1, w(32'h4),         32'h4,        32'h8);
    tbl[5]  = v(0, 0, 0, 32'h0,        1, w(32'h8),        1, 32'hC,        1, w(32'h8),         32'h8,        32'hC);
    tbl[6]  = v(0, 0, 0, 32'h0,        1, w(32'hC),        1, 32'h10,       1, w(32'hC),         32'hC,        32'h10);
    tbl[7]  = v(0, 0, 0, 32'h0,        0, 32'h0,           1, 32'h10,       0, w(32'hC),         32'hC,        32'h10);
    tbl[8]  = v(0, 0, 0, 32'h0,        0, 32'h0,           1, 32'h10,       0, w(32'hC),         32'hC,        32'h10);
    tbl[9]  = v(0, 0, 0, 32'h0,        1, w(32'h10),       1, 32'h14,       1, w(32'h10),        32'h10,       32'h14);
    tbl[10] = v(0, 0, 0, 32'h0,        0, 32'h0,           1, 32'h14,       0, w(32'h10),        32'h10,       32'h14);
    tbl[11] = v(0, 0, 0, 32'h0,        0, 32'h0,           1, 32'h14,       0, w(32'h10),        32'h10,       32'h14);
    tbl[12] = v(0, 0, 0, 32'h0,        1, w(32'h14),       1, 32'h18,       1, w(32'h14),        32'h14,       32'h18);
    tbl[13] = v(0, 1, 0, 32'h0,        0, 32'h0,           1, 32'h18,       1, w(32'h14),        32'h14,       32'h18);
    tbl[14] = v(0, 1, 1, 32'hFFFF_FFFE,0, 32'h0,           0, 32'hFFFF_FFFC,0, NOP,              32'h14,       32'h18);
    tbl[15] = v(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF,   1, 32'hFFFF_FFFC,0, NOP,              32'h14,       32'h18);
    tbl[16] = v(0, 0, 0, 32'h0,        1, w(32'hFFFF_FFFC),1, 32'h0,        1, 32'h5A5A_FFFC,    32'hFFFF_FFFC,32'h0);
    tbl[17] = v(0, 0, 0, 32'h0,        1, w(32'h0),        1, 32'h4,        1, w(32'h0),         32'h0,        32'h4);
    tbl[18] = v(0, 1, 1, 32'h40,       1, 32'h1111_1111,   1, 32'h40,       0, NOP,              32'h0,        32'h4);
    tbl[19] = v(0, 0, 0, 32'h0,        1, w(32'h40),       1, 32'h44,       1, w(32'h40),        32'h40,       32'h44);

    for (int i = 0; i < 20; i++) apply(tbl[i], i);

    // Stall on the returning word at pc 8 parks it in the skid buffer.
    apply(v(1,0,0,0,0,0,             0,32'h0, 0,NOP,0,4), 100);
    apply(v(0,0,0,0,0,0,             1,32'h0, 0,NOP,0,4), 101);
    apply(v(0,0,0,0,1,w(32'h0),      1,32'h4, 1,w(32'h0),32'h0,32'h4), 102);
    apply(v(0,0,0,0,1,w(32'h4),      1,32'h8, 1,w(32'h4),32'h4,32'h8), 103);
    apply(v(0,1,0,0,1,32'h0050_0093, 0,32'h8, 1,w(32'h4),32'h4,32'h8), 104);
    apply(v(0,1,0,0,0,0,             0,32'h8, 1,w(32'h4),32'h4,32'h8), 105);
    apply(v(0,0,0,0,0,0,             1,32'hC, 1,32'h0050_0093,32'h8,32'hC), 106);
    apply(v(0,0,0,0,1,w(32'hC),      1,32'h10,1,w(32'hC),32'hC,32'h10), 107);

    // Redirect while the 0x10 request is still outstanding; its reply is dropped.
    apply(v(0,0,1,32'h102,0,0,       0,32'h100,0,NOP,32'hC,32'h10), 200);
    apply(v(0,0,0,0,0,0,             0,32'h100,0,NOP,32'hC,32'h10), 201);
    apply(v(0,0,0,0,1,w(32'h10),     1,32'h100,0,NOP,32'hC,32'h10), 202);
    apply(v(0,0,0,0,1,w(32'h100),    1,32'h104,1,w(32'h100),32'h100,32'h104), 203);

    // Reset mid-request with a response arriving in the same cycle.
    apply(v(1,0,0,0,1,w(32'h104),    0,32'h0, 0,NOP,32'h0,32'h4), 300);
    apply(v(0,0,0,0,0,0,             1,32'h0, 0,NOP,32'h0,32'h4), 301);
    apply(v(0,0,0,0,1,w(32'h0),      1,32'h4, 1,w(32'h0),32'h0,32'h4), 302);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
